// File: rtl/nco_ring_mod_pkg.sv
// rtl/nco_ring_mod_pkg.sv - shared types, defaults and sine table helper for nco_ring_mod
package nco_ring_mod_pkg;

  typedef enum logic [1:0] {
    MODE_RING  = 2'b00,
    MODE_AM    = 2'b01,
    MODE_AONLY = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_LUT_AW  = 8;
  localparam int DEF_SAMP_W  = 8;
  localparam int DEF_OUT_W   = 8;

  // Quarter-wave entries are non-negative, so adding one half before
  // truncation rounds to nearest. Evaluated at elaboration only.
  function automatic int quarter_sine(input int i, input int lut_aw, input int samp_w);
    real amp;
    real ang;
    amp = real'((1 << (samp_w - 1)) - 1);
    ang = 2.0 * 3.14159265358979 * real'(i) / real'(1 << lut_aw);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/nco_ring_mod_lut.sv
// rtl/nco_ring_mod_lut.sv - full-wave sine lookup built from a quarter-wave table
module sine_quarter_lut import nco_ring_mod_pkg::*; #(
  parameter int LUT_AW = DEF_LUT_AW,
  parameter int SAMP_W = DEF_SAMP_W
) (
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [SAMP_W-1:0] sample
);

  localparam int QN = 1 << (LUT_AW - 2);

  // QN+1 entries so the 90 degree peak is stored exactly instead of mirrored.
  logic [SAMP_W-1:0] quarter_tab [0:QN];

  for (genvar i = 0; i <= QN; i++) begin : g_tab
    assign quarter_tab[i] = SAMP_W'(quarter_sine(i, LUT_AW, SAMP_W));
  end

  logic [1:0]        quad;
  logic [LUT_AW-3:0] idx;
  logic [LUT_AW-2:0] tab_idx;
  logic [SAMP_W-1:0] mag;

  // Odd quadrants walk the table backwards; the upper half-wave is negated.
  always_comb begin
    quad = addr[LUT_AW-1:LUT_AW-2];
    idx  = addr[LUT_AW-3:0];
    if (quad[0]) begin
      tab_idx = (LUT_AW-1)'(QN) - {1'b0, idx};
    end else begin
      tab_idx = {1'b0, idx};
    end
    mag    = quarter_tab[tab_idx];
    sample = quad[1] ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/nco_ring_mod.sv
// rtl/nco_ring_mod.sv - dual NCO ring modulator with wrap-synchronous config update
module nco_ring_mod import nco_ring_mod_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int LUT_AW  = DEF_LUT_AW,
  parameter int SAMP_W  = DEF_SAMP_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               sync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_incr_a,
  input  logic [PHASE_W-1:0] cfg_incr_b,
  input  logic [1:0]         cfg_mode,
  input  logic [1:0]         cfg_shift_b,
  output logic [OUT_W-1:0]   out_sample,
  output logic               out_valid
);

  localparam int PROD_W = 2 * SAMP_W;
  localparam int RSH    = 2 * SAMP_W - 1 - OUT_W;
  localparam logic signed [SAMP_W-1:0] FULL     = SAMP_W'((1 << (SAMP_W - 1)) - 1);
  localparam logic signed [SAMP_W-1:0] AM_OFS   = SAMP_W'(1 << (SAMP_W - 2));
  localparam logic signed [PROD_W-1:0] CLAMP_HI = PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] CLAMP_LO = -CLAMP_HI;
  localparam logic [OUT_W-1:0]         MID      = OUT_W'(1 << (OUT_W - 1));

  // Active and pending configuration.
  logic [PHASE_W-1:0] incr_a, incr_b, pend_incr_a, pend_incr_b;
  mode_e              mode, pend_mode;
  logic [1:0]         shift_b, pend_shift_b;
  logic               pend_valid;

  logic [PHASE_W-1:0] phase_a, phase_b;
  logic [PHASE_W:0]   sum_a;
  logic               cfg_fire, apply_cfg, launch;

  assign sum_a     = {1'b0, phase_a} + {1'b0, incr_a};
  assign cfg_ready = !pend_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign launch    = sample_en && !sync;
  // A zero increment never wraps, so any sample strobe is a safe switch point.
  assign apply_cfg = pend_valid &&
                     (sync || (sample_en && (sum_a[PHASE_W] || incr_a == '0)));

  // Accept offers into the pending slot; promote it at a wrap or on sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incr_a       <= '0;
      incr_b       <= '0;
      mode         <= MODE_MUTE;
      shift_b      <= '0;
      pend_incr_a  <= '0;
      pend_incr_b  <= '0;
      pend_mode    <= MODE_MUTE;
      pend_shift_b <= '0;
      pend_valid   <= 1'b0;
    end else if (cfg_fire) begin
      pend_incr_a  <= cfg_incr_a;
      pend_incr_b  <= cfg_incr_b;
      pend_mode    <= mode_e'(cfg_mode);
      pend_shift_b <= cfg_shift_b;
      pend_valid   <= 1'b1;
    end else if (apply_cfg) begin
      incr_a     <= pend_incr_a;
      incr_b     <= pend_incr_b;
      mode       <= pend_mode;
      shift_b    <= pend_shift_b;
      pend_valid <= 1'b0;
    end
  end

  // Phase accumulators; sync wins over the sample strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_a <= '0;
      phase_b <= '0;
    end else if (sync) begin
      phase_a <= '0;
      phase_b <= '0;
    end else if (sample_en) begin
      phase_a <= sum_a[PHASE_W-1:0];
      phase_b <= phase_b + incr_b;
    end
  end

  // P0: the LUTs read the pre-update phases in the launch cycle.
  logic signed [SAMP_W-1:0] lut_a, lut_b;

  sine_quarter_lut #(.LUT_AW(LUT_AW), .SAMP_W(SAMP_W)) u_lut_a (
    .addr   (phase_a[PHASE_W-1 -: LUT_AW]),
    .sample (lut_a)
  );

  sine_quarter_lut #(.LUT_AW(LUT_AW), .SAMP_W(SAMP_W)) u_lut_b (
    .addr   (phase_b[PHASE_W-1 -: LUT_AW]),
    .sample (lut_b)
  );

  logic                     v1, v2, mute2;
  logic signed [SAMP_W-1:0] sa1, sb1, b_eff;
  mode_e                    mode1;
  logic [1:0]               shift1;
  logic signed [PROD_W-1:0] prod2, scaled;
  logic signed [OUT_W-1:0]  res;

  // P1: register sines together with the mode active at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      sa1    <= '0;
      sb1    <= '0;
      mode1  <= MODE_MUTE;
      shift1 <= '0;
    end else begin
      v1 <= launch;
      if (launch) begin
        sa1    <= lut_a;
        sb1    <= lut_b;
        mode1  <= mode;
        shift1 <= shift_b;
      end
    end
  end

  // Effective B operand for each mode.
  always_comb begin
    b_eff = '0;
    case (mode1)
      MODE_RING:  b_eff = sb1 >>> shift1;
      MODE_AM:    b_eff = (sb1 >>> ({1'b0, shift1} + 3'd1)) + AM_OFS;
      MODE_AONLY: b_eff = FULL >>> shift1;
      default:    b_eff = '0;
    endcase
  end

  // P2: full-precision signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      mute2 <= 1'b0;
      prod2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        prod2 <= PROD_W'(sa1) * PROD_W'(b_eff);
        mute2 <= (mode1 == MODE_MUTE);
      end
    end
  end

  // Floor-scale then clamp symmetrically so the code never reaches 0.
  always_comb begin
    scaled = prod2 >>> RSH;
    if (scaled > CLAMP_HI) begin
      res = CLAMP_HI[OUT_W-1:0];
    end else if (scaled < CLAMP_LO) begin
      res = CLAMP_LO[OUT_W-1:0];
    end else begin
      res = scaled[OUT_W-1:0];
    end
  end

  // P3: offset-binary output, held between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sample <= MID;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_sample <= mute2 ? MID : {~res[OUT_W-1], res[OUT_W-2:0]};
      end
    end
  end

endmodule

// File: tb/tb_nco_ring_mod.sv
// tb/tb_nco_ring_mod.sv - directed self-checking bench for nco_ring_mod
module tb_nco_ring_mod;
  import nco_ring_mod_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_incr_a = '0;
  logic [15:0] cfg_incr_b = '0;
  logic [1:0]  cfg_mode = '0;
  logic [1:0]  cfg_shift_b = '0;
  logic [7:0]  out_sample;
  logic        out_valid;

  nco_ring_mod dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .sync        (sync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_incr_a  (cfg_incr_a),
    .cfg_incr_b  (cfg_incr_b),
    .cfg_mode    (cfg_mode),
    .cfg_shift_b (cfg_shift_b),
    .out_sample  (out_sample),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int got_q[$];
  int got_cyc[$];
  int launch_cyc[$];
  int exp_q[$];

  always @(negedge clk) begin
    if (out_valid) begin
      got_q.push_back(int'(out_sample));
      got_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    launch_cyc.delete();
  endtask

  task automatic send_cfg(input logic [15:0] ia, input logic [15:0] ib,
                          input logic [1:0] m, input logic [1:0] s);
    cfg_incr_a  = ia;
    cfg_incr_b  = ib;
    cfg_mode    = m;
    cfg_shift_b = s;
    cfg_valid   = 1'b1;
    check_eq("cfg_offer_ready", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    check_eq("cfg_pending", int'(cfg_ready), 0);
  endtask

  task automatic do_sync();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  task automatic run_samples(input int n);
    for (int i = 0; i < n; i++) begin
      sample_en = 1'b1;
      launch_cyc.push_back(cyc);
      step();
    end
    sample_en = 1'b0;
    repeat (4) step();
  endtask

  task automatic expect_seq(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
      if (i < launch_cyc.size())
        check_eq($sformatf("%s_lat%0d", tag, i), got_cyc[i] - launch_cyc[i], 3);
    end
  endtask

  initial begin
    int n_en;

    // Reset values
    step();
    check_eq("reset_sample", int'(out_sample), 128);
    check_eq("reset_valid", int'(out_valid), 0);
    check_eq("reset_ready", int'(cfg_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    // A-only tone, quarter-cycle steps
    send_cfg(16'h4000, 16'h0000, 2'b10, 2'd0);
    do_sync();
    check_eq("sync_ready", int'(cfg_ready), 1);
    clear_q();
    run_samples(4);
    exp_q = '{128, 254, 128, 1};
    expect_seq("aonly");

    // Wrap-synchronous config update
    clear_q();
    run_samples(1);
    send_cfg(16'h1000, 16'h0000, 2'b10, 2'd0);
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      sample_en = 1'b1;
      launch_cyc.push_back(cyc);
      step();
      n_en++;
      if (cfg_ready) break;
    end
    sample_en = 1'b0;
    check_eq("glitch_busy_samples", n_en, 3);
    run_samples(3);
    exp_q = '{128, 254, 128, 1, 128, 176, 217};
    expect_seq("glitch");

    // Ring with B held at phase 0
    send_cfg(16'h4000, 16'h0000, 2'b00, 2'd0);
    do_sync();
    clear_q();
    run_samples(4);
    exp_q = '{128, 128, 128, 128};
    expect_seq("ring_b0");

    // Ring with B attenuated by one
    send_cfg(16'h4000, 16'h4000, 2'b00, 2'd1);
    do_sync();
    clear_q();
    run_samples(4);
    exp_q = '{128, 190, 128, 191};
    expect_seq("ring_sh1");

    // AM with B at phase 0
    send_cfg(16'h4000, 16'h0000, 2'b01, 2'd0);
    do_sync();
    clear_q();
    run_samples(4);
    exp_q = '{128, 191, 128, 64};
    expect_seq("am");

    // sync together with sample_en
    run_samples(1);
    clear_q();
    send_cfg(16'h4000, 16'h0000, 2'b10, 2'd0);
    sync = 1'b1;
    sample_en = 1'b1;
    step();
    sync = 1'b0;
    sample_en = 1'b0;
    check_eq("syncen_ready", int'(cfg_ready), 1);
    repeat (5) step();
    check_eq("syncen_no_valid", got_q.size(), 0);
    clear_q();
    run_samples(2);
    exp_q = '{128, 254};
    expect_seq("syncen_after");

    // Back-to-back mute
    send_cfg(16'h0000, 16'h0000, 2'b11, 2'd0);
    do_sync();
    clear_q();
    run_samples(20);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(128);
    expect_seq("mute");

    // Asynchronous reset mid-pipeline
    send_cfg(16'h1000, 16'h0000, 2'b10, 2'd0);
    do_sync();
    send_cfg(16'h4000, 16'h0000, 2'b00, 2'd0);
    sample_en = 1'b1;
    repeat (5) step();
    check_eq("prereset_sample", int'(out_sample), 217);
    check_eq("prereset_valid", int'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    sample_en = 1'b0;
    #1;
    check_eq("async_reset_sample", int'(out_sample), 128);
    check_eq("async_reset_valid", int'(out_valid), 0);
    check_eq("async_reset_ready", int'(cfg_ready), 1);
    step();
    step();
    rst_n = 1'b1;
    clear_q();
    repeat (5) step();
    check_eq("postreset_no_valid", got_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
